// File: rtl/vga_line_fetch_if.sv
// Frame-memory read port of the VGA line fetcher: req/ack handshake, data valid with ack.
// The fetcher is the master; the frame memory (or its arbiter) is the slave.
interface vga_line_fetch_if #(
    parameter int ADDR_W = 19
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/vga_line_fetch.sv
// Ping-pong scanline prefetcher: while line y is displayed from one buffer, line y+1 is
// fetched from RGB565 frame memory into the other; pixels leave as registered 8:8:8.
module vga_line_fetch #(
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480,
    parameter int ADDR_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic [ADDR_W-1:0]       fb_base,
    output logic [7:0]              r,
    output logic [7:0]              g,
    output logic [7:0]              b,
    output logic                    underrun,
    input  logic                    under_clr,
    vga_line_fetch_if.master        mem
);
    localparam int CNT_W = $clog2(H_ACT);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    // Replicate the top bits of each RGB565 field into the low bits so full scale maps to 8'hFF.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              mem_req_r;
    logic              wsel_r;
    logic [9:0]        line_r;
    logic [9:0]        y_prev_r;
    logic [1:0]        vld_r;
    logic [9:0]        tag_r [2];
    logic [23:0]       rgb_r;
    logic              underrun_r;

    logic [15:0]       buf0_r [H_ACT];
    logic [15:0]       buf1_r [H_ACT];

    logic              trig_s;
    logic [9:0]        line_s;
    logic [ADDR_W-1:0] base_s;
    logic              abort_s;
    logic              wr_s;
    logic              act_s;
    logic              hit_s;
    logic [15:0]       rd_word_s;
    logic [23:0]       pix_s;
    logic              set_s;

    // Line trigger, next line index and its base word address.
    always_comb begin
        trig_s = (y != y_prev_r);
        if (y == 10'(V_ACT - 1)) begin
            line_s = 10'd0;
        end else begin
            line_s = y + 10'd1;
        end
        base_s  = fb_base + ADDR_W'(line_s) * ADDR_W'(H_ACT);
        abort_s = trig_s && (state_r == FETCH);
        wr_s    = (state_r == FETCH) && mem.mem_ack && !trig_s;
    end

    // Display-side lookup: the buffer selected by y[0] is valid only if its tag names line y.
    always_comb begin
        act_s = (x < 10'(H_ACT)) && (y < 10'(V_ACT));
        hit_s = vld_r[y[0]] && (tag_r[y[0]] == y);
        if (act_s && hit_s) begin
            if (y[0]) begin
                rd_word_s = buf1_r[x];
            end else begin
                rd_word_s = buf0_r[x];
            end
            pix_s = rgb565_to_888(rd_word_s);
        end else begin
            rd_word_s = 16'h0000;
            pix_s     = 24'h000000;
        end
        set_s = abort_s || (act_s && !hit_s);
    end

    // Fetch FSM: a new line trigger always wins, restarting the fetch even mid-line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            addr_r    <= '0;
            mem_req_r <= 1'b0;
            wsel_r    <= 1'b0;
            line_r    <= 10'd0;
            y_prev_r  <= 10'h3FF;
            vld_r     <= 2'b00;
            tag_r[0]  <= 10'd0;
            tag_r[1]  <= 10'd0;
        end else if (trig_s) begin
            y_prev_r      <= y;
            state_r       <= FETCH;
            cnt_r         <= '0;
            addr_r        <= base_s;
            mem_req_r     <= 1'b1;
            wsel_r        <= line_s[0];
            line_r        <= line_s;
            vld_r[line_s[0]] <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mem_req_r <= 1'b0;
                end
                FETCH: begin
                    if (mem.mem_ack) begin
                        if (cnt_r == CNT_W'(H_ACT - 1)) begin
                            state_r       <= IDLE;
                            mem_req_r     <= 1'b0;
                            vld_r[wsel_r] <= 1'b1;
                            tag_r[wsel_r] <= line_r;
                        end else begin
                            cnt_r  <= cnt_r + CNT_W'(1);
                            addr_r <= addr_r + ADDR_W'(1);
                        end
                    end else begin
                        mem_req_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Line buffer write port; left without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            if (wsel_r) begin
                buf1_r[cnt_r] <= mem.mem_data;
            end else begin
                buf0_r[cnt_r] <= mem.mem_data;
            end
        end
    end

    // Registered pixel output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_r <= 24'h000000;
        end else begin
            rgb_r <= pix_s;
        end
    end

    // Sticky underrun flag; a new event beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_r <= 1'b0;
        end else if (set_s) begin
            underrun_r <= 1'b1;
        end else if (under_clr) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    assign mem.mem_req  = mem_req_r;
    assign mem.mem_addr = addr_r;
    assign {r, g, b}    = rgb_r;
    assign underrun     = underrun_r;
endmodule
